// File: rtl/bcd_display_engine_pkg.sv
// Shared types and constants for the BCD display engine.
// State encoding, segment patterns and the double-dabble digit correction.
package display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [3:0] BCD_ADD3_THRESH = 4'd5;

    // Pre-shift correction so the digit carries into the next decade.
    function automatic logic [3:0] bcd_add3(input logic [3:0] d);
        return (d >= BCD_ADD3_THRESH) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/bcd_display_engine_if.sv
// Conversion request/result bundle between a client and the engine.
// The client drives val/start; the engine returns status and display.
interface bcd_display_engine_if #(
    parameter int WIDTH  = 17,
    parameter int DIGITS = 6
);
    logic [WIDTH-1:0]    val;
    logic                start;
    logic                busy;
    logic                done;
    logic                overflow;
    logic [4*DIGITS-1:0] bcd;
    logic [7*DIGITS-1:0] seg7;

    modport master (
        output val, start,
        input  busy, done, overflow, bcd, seg7
    );

    modport slave (
        input  val, start,
        output busy, done, overflow, bcd, seg7
    );
endinterface

// File: rtl/bcd_display_engine_seg.sv
// Active-low seven-segment decoder, bit 0 = segment a, bit 6 = g.
// Non-decimal codes show blank.
module seven_segment
    import display_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Decimal digit to segment pattern.
    always_comb begin
        seg = SEG_BLANK;
        unique case (1'b1)
            (digit == 4'd0): seg = 7'b1000000;
            (digit == 4'd1): seg = 7'b1111001;
            (digit == 4'd2): seg = 7'b0100100;
            (digit == 4'd3): seg = 7'b0110000;
            (digit == 4'd4): seg = 7'b0011001;
            (digit == 4'd5): seg = 7'b0010010;
            (digit == 4'd6): seg = 7'b0000010;
            (digit == 4'd7): seg = 7'b1111000;
            (digit == 4'd8): seg = 7'b0000000;
            (digit == 4'd9): seg = 7'b0010000;
            default:         seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_display_engine.sv
// Sequential double-dabble converter driving DIGITS seven-segment displays.
// Results and display only change on commit; signed, blanking, overflow.
module bcd_display_engine
    import display_pkg::*;
#(
    parameter int WIDTH       = 17,
    parameter int DIGITS      = 6,
    parameter int SIGNED_MODE = 0,
    parameter int BLANK_LZ    = 1
) (
    input logic clk,
    input logic rst,
    bcd_display_engine_if.slave bus
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;
    localparam int SW = 7 * DIGITS;

    state_t           state, state_n;
    logic [WIDTH-1:0] mag, mag_n;
    logic [BW-1:0]    work, work_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             ovf_acc, ovf_acc_n;
    logic             neg_w, neg_w_n;
    logic [BW-1:0]    bcd_q, bcd_n;
    logic             ovf_q, ovf_n;
    logic             neg_q, neg_n;
    logic             busy, done;

    logic [BW-1:0]    adj;
    logic [WIDTH-1:0] val_neg;
    logic             in_neg;
    logic [SW-1:0]    dec;
    logic [SW-1:0]    seg;
    int               hi;
    int               mpos;

    assign val_neg = ~bus.val + WIDTH'(1);
    assign in_neg  = (SIGNED_MODE != 0) && bus.val[WIDTH-1];

    // Per-digit +3 correction applied before each shift.
    always_comb begin
        adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            adj[4*i+:4] = bcd_add3(work[4*i+:4]);
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            mag     <= '0;
            work    <= '0;
            cnt     <= '0;
            ovf_acc <= 1'b0;
            neg_w   <= 1'b0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            state   <= state_n;
            mag     <= mag_n;
            work    <= work_n;
            cnt     <= cnt_n;
            ovf_acc <= ovf_acc_n;
            neg_w   <= neg_w_n;
            bcd_q   <= bcd_n;
            ovf_q   <= ovf_n;
            neg_q   <= neg_n;
        end
    end

    // Next-state, shift datapath and handshake outputs.
    always_comb begin
        state_n   = state;
        mag_n     = mag;
        work_n    = work;
        cnt_n     = cnt;
        ovf_acc_n = ovf_acc;
        neg_w_n   = neg_w;
        bcd_n     = bcd_q;
        ovf_n     = ovf_q;
        neg_n     = neg_q;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    mag_n     = in_neg ? val_neg : bus.val;
                    neg_w_n   = in_neg;
                    work_n    = '0;
                    ovf_acc_n = 1'b0;
                    cnt_n     = CW'(WIDTH);
                    state_n   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy      = 1'b1;
                work_n    = {adj[BW-2:0], mag[WIDTH-1]};
                mag_n     = {mag[WIDTH-2:0], 1'b0};
                ovf_acc_n = ovf_acc | adj[BW-1];
                cnt_n     = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_n = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                busy    = 1'b1;
                done    = 1'b1;
                bcd_n   = work;
                ovf_n   = ovf_acc
                        | (neg_w & (work[BW-1:BW-4] != 4'd0));
                neg_n   = neg_w;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        seven_segment u_seg (
            .digit (bcd_q[4*g+:4]),
            .seg   (dec[7*g+:7])
        );
    end

    // Overflow dashes, sign placement and leading-zero blanking.
    always_comb begin
        hi = 0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i+:4] != 4'd0) begin
                hi = i;
            end
        end
        mpos = (BLANK_LZ != 0) ? hi + 1 : DIGITS - 1;
        seg  = dec;
        for (int i = 0; i < DIGITS; i++) begin
            if (ovf_q) begin
                seg[7*i+:7] = SEG_MINUS;
            end else if (neg_q && (i == mpos)) begin
                seg[7*i+:7] = SEG_MINUS;
            end else if ((BLANK_LZ != 0) && (i > hi)) begin
                seg[7*i+:7] = SEG_BLANK;
            end
        end
    end

    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.overflow = ovf_q;
    assign bus.bcd      = bcd_q;
    assign bus.seg7     = seg;

endmodule

// File: tb/tb_bcd_display_engine.sv
// Randomised bench for bcd_display_engine over four parameter sets.
// Expected results come from a decimal arithmetic reference model.
module tb_bcd_display_engine;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bcd_display_engine_if #(.WIDTH(17), .DIGITS(6)) ifa ();
    bcd_display_engine_if #(.WIDTH(8),  .DIGITS(4)) ifb ();
    bcd_display_engine_if #(.WIDTH(8),  .DIGITS(2)) ifc ();
    bcd_display_engine_if #(.WIDTH(8),  .DIGITS(4)) ifd ();

    bcd_display_engine #(
        .WIDTH(17), .DIGITS(6), .SIGNED_MODE(0), .BLANK_LZ(1)
    ) dut_a (.clk(clk), .rst(rst), .bus(ifa));

    bcd_display_engine #(
        .WIDTH(8), .DIGITS(4), .SIGNED_MODE(1), .BLANK_LZ(1)
    ) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    bcd_display_engine #(
        .WIDTH(8), .DIGITS(2), .SIGNED_MODE(0), .BLANK_LZ(1)
    ) dut_c (.clk(clk), .rst(rst), .bus(ifc));

    bcd_display_engine #(
        .WIDTH(8), .DIGITS(4), .SIGNED_MODE(1), .BLANK_LZ(0)
    ) dut_d (.clk(clk), .rst(rst), .bus(ifd));

    int cw[4] = '{17, 8, 8, 8};
    int cd[4] = '{6, 4, 2, 4};
    int cs[4] = '{0, 1, 0, 1};
    int cb[4] = '{1, 1, 1, 0};

    logic [6:0] segtab[10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    logic [63:0] obcd[4];
    logic [47:0] oseg[4];
    logic [3:0]  obusy, odone, oovf;

    assign obcd[0] = 64'(ifa.bcd);
    assign obcd[1] = 64'(ifb.bcd);
    assign obcd[2] = 64'(ifc.bcd);
    assign obcd[3] = 64'(ifd.bcd);
    assign oseg[0] = 48'(ifa.seg7);
    assign oseg[1] = 48'(ifb.seg7);
    assign oseg[2] = 48'(ifc.seg7);
    assign oseg[3] = 48'(ifd.seg7);
    assign obusy = {ifd.busy, ifc.busy, ifb.busy, ifa.busy};
    assign odone = {ifd.done, ifc.done, ifb.done, ifa.done};
    assign oovf  = {ifd.overflow, ifc.overflow,
                    ifb.overflow, ifa.overflow};

    int     errors = 0;
    int     checks = 0;
    longint vin[4];
    int     done_at[4];
    int     ndone[4];
    int     busy_bad[4];
    int     stab_bad[4];

    // Decimal reference: value -> committed digits, flag, display.
    function automatic void model(
        input  int          k,
        input  longint      v,
        output longint      eb,
        output bit          eo,
        output logic [47:0] es
    );
        longint mag, p, t;
        bit     neg;
        int     dg[6];
        int     h, mp;
        neg = (cs[k] != 0) && (((v >> (cw[k] - 1)) & 1) != 0);
        mag = neg ? (longint'(1) << cw[k]) - v : v;
        p = 1;
        for (int i = 0; i < cd[k]; i++) p = p * 10;
        eo = (mag >= p) || (neg && (mag >= p / 10));
        t  = mag % p;
        eb = 0;
        h  = 0;
        for (int i = 0; i < 6; i++) dg[i] = 0;
        for (int i = 0; i < cd[k]; i++) begin
            dg[i] = int'(t % 10);
            t = t / 10;
            eb = eb | (longint'(dg[i]) << (4 * i));
            if (dg[i] != 0) h = i;
        end
        mp = (cb[k] != 0) ? h + 1 : cd[k] - 1;
        es = '0;
        for (int i = 0; i < cd[k]; i++) begin
            if (eo)
                es[7*i+:7] = 7'h3F;
            else if (neg && i == mp)
                es[7*i+:7] = 7'h3F;
            else if (cb[k] != 0 && i > h)
                es[7*i+:7] = 7'h7F;
            else
                es[7*i+:7] = segtab[dg[i]];
        end
    endfunction

    function automatic longint rnd(input int k);
        longint r;
        r = longint'($urandom);
        return r & ((longint'(1) << cw[k]) - 1);
    endfunction

    task automatic set_in(input int k, input longint v,
                          input logic s);
        case (k)
            0: begin ifa.val = v[16:0]; ifa.start = s; end
            1: begin ifb.val = v[7:0];  ifb.start = s; end
            2: begin ifc.val = v[7:0];  ifc.start = s; end
            default: begin ifd.val = v[7:0]; ifd.start = s; end
        endcase
    endtask

    // Start all four engines with vin[]; sp keeps start high
    // with fresh random values until each engine reports done.
    task automatic run_conv(input bit sp);
        logic [47:0] rs[4];
        logic [63:0] rb[4];
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            set_in(k, vin[k], 1'b1);
            done_at[k]  = -1;
            ndone[k]    = 0;
            busy_bad[k] = 0;
            stab_bad[k] = 0;
        end
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                if (c == 1) begin
                    rs[k] = oseg[k];
                    rb[k] = obcd[k];
                end
                if (odone[k]) begin
                    ndone[k]++;
                    if (done_at[k] < 0) done_at[k] = c;
                end
                if (obusy[k] !== (c <= cw[k] + 1))
                    busy_bad[k]++;
                if (c <= cw[k] + 1 &&
                    (oseg[k] !== rs[k] || obcd[k] !== rb[k]))
                    stab_bad[k]++;
                if (sp && done_at[k] < 0)
                    set_in(k, rnd(k), 1'b1);
                else
                    set_in(k, vin[k], 1'b0);
            end
        end
    endtask

    task automatic test_reset();
        longint eb;
        bit eo;
        logic [47:0] es;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            model(k, 0, eb, eo, es);
            checks++;
            if (obusy[k] !== 1'b0 || odone[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_hs dut%0d: busy=%b done=%b want 0/0",
                         k, obusy[k], odone[k]);
            end
            checks++;
            if (oovf[k] !== 1'b0 || obcd[k] !== 64'd0) begin
                errors++;
                $display("FAIL reset_val dut%0d: ovf=%b bcd=%h want 0/0",
                         k, oovf[k], obcd[k]);
            end
            checks++;
            if (oseg[k] !== es) begin
                errors++;
                $display("FAIL reset_seg dut%0d: got %h want %h",
                         k, oseg[k], es);
            end
        end
        rst = 1'b1;
    endtask

    task automatic test_directed();
        vin[0] = 0;
        vin[1] = 64'hD6;
        vin[2] = 100;
        vin[3] = 64'hD6;
        run_conv(1'b0);
        checks++;
        if (ifa.bcd !== 24'h000000 ||
            ifa.seg7 !== {{35{1'b1}}, 7'h40}) begin
            errors++;
            $display("FAIL zero: bcd=%h seg=%h want 000000/blank+0",
                     ifa.bcd, ifa.seg7);
        end
        checks++;
        if (ifb.bcd !== 16'h0042 ||
            ifb.seg7 !== {7'h7F, 7'h3F, 7'h19, 7'h24}) begin
            errors++;
            $display("FAIL neg42: bcd=%h seg=%h want 0042/_-42",
                     ifb.bcd, ifb.seg7);
        end
        checks++;
        if (ifc.overflow !== 1'b1 ||
            ifc.seg7 !== {7'h3F, 7'h3F}) begin
            errors++;
            $display("FAIL ovf100: ovf=%b seg=%h want 1/--",
                     ifc.overflow, ifc.seg7);
        end
        checks++;
        if (ifd.seg7 !== {7'h3F, 7'h40, 7'h19, 7'h24}) begin
            errors++;
            $display("FAIL neg42_nolz: seg=%h want -042",
                     ifd.seg7);
        end
        vin[0] = 131071;
        vin[1] = 64'h80;
        vin[2] = 99;
        vin[3] = 64'h80;
        run_conv(1'b0);
        checks++;
        if (ifa.bcd !== 24'h131071 || ifa.overflow !== 1'b0 ||
            ifa.seg7 !== {7'h79, 7'h30, 7'h79, 7'h40,
                          7'h78, 7'h79}) begin
            errors++;
            $display("FAIL max: bcd=%h ovf=%b seg=%h want 131071",
                     ifa.bcd, ifa.overflow, ifa.seg7);
        end
        checks++;
        if (ifb.bcd !== 16'h0128 ||
            ifb.seg7[27:21] !== 7'h3F) begin
            errors++;
            $display("FAIL minneg: bcd=%h seg=%h want 0128/-128",
                     ifb.bcd, ifb.seg7);
        end
        checks++;
        if (ifc.overflow !== 1'b0 || ifc.bcd !== 8'h99 ||
            ifc.seg7 !== {7'h10, 7'h10}) begin
            errors++;
            $display("FAIL v99: ovf=%b bcd=%h seg=%h want 0/99",
                     ifc.overflow, ifc.bcd, ifc.seg7);
        end
        checks++;
        if (done_at[0] !== 18 || done_at[1] !== 9) begin
            errors++;
            $display("FAIL latency: a=%0d b=%0d want 18/9",
                     done_at[0], done_at[1]);
        end
    endtask

    task automatic test_random();
        longint eb;
        bit eo;
        logic [47:0] es;
        for (int it = 0; it < 25; it++) begin
            for (int k = 0; k < 4; k++) vin[k] = rnd(k);
            run_conv(1'b0);
            for (int k = 0; k < 4; k++) begin
                model(k, vin[k], eb, eo, es);
                checks++;
                if (obcd[k] !== 64'(eb) || oovf[k] !== eo ||
                    oseg[k] !== es) begin
                    errors++;
                    $display("FAIL rand dut%0d v=%0h: bcd=%h ovf=%b seg=%h want %h %b %h",
                             k, vin[k], obcd[k], oovf[k],
                             oseg[k], eb, eo, es);
                end
                checks++;
                if (done_at[k] !== cw[k] + 1 || ndone[k] !== 1 ||
                    busy_bad[k] !== 0 || stab_bad[k] !== 0) begin
                    errors++;
                    $display("FAIL rand_hs dut%0d: done@%0d n=%0d busy_bad=%0d stab_bad=%0d want %0d 1 0 0",
                             k, done_at[k], ndone[k], busy_bad[k],
                             stab_bad[k], cw[k] + 1);
                end
            end
        end
    endtask

    task automatic test_start_spam();
        longint eb;
        bit eo;
        logic [47:0] es;
        for (int it = 0; it < 4; it++) begin
            for (int k = 0; k < 4; k++) vin[k] = rnd(k);
            run_conv(1'b1);
            for (int k = 0; k < 4; k++) begin
                model(k, vin[k], eb, eo, es);
                checks++;
                if (ndone[k] !== 1 || stab_bad[k] !== 0 ||
                    obcd[k] !== 64'(eb) || oseg[k] !== es) begin
                    errors++;
                    $display("FAIL spam dut%0d: n=%0d stab_bad=%0d bcd=%h seg=%h want 1 0 %h %h",
                             k, ndone[k], stab_bad[k], obcd[k],
                             oseg[k], eb, es);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        longint v1, v2, eb;
        bit eo;
        logic [47:0] es;
        int n;
        v1 = rnd(0);
        v2 = rnd(0);
        @(negedge clk);
        ifa.val   = v1[16:0];
        ifa.start = 1'b1;
        n = 0;
        for (int c = 1; c <= 40 && n == 0; c++) begin
            @(negedge clk);
            ifa.start = 1'b0;
            ifa.val   = v2[16:0];
            if (ifa.done) n = c;
        end
        checks++;
        if (n !== 18) begin
            errors++;
            $display("FAIL b2b_first: done@%0d want 18", n);
        end
        @(negedge clk);
        model(0, v1, eb, eo, es);
        checks++;
        if (ifa.bcd !== 24'(eb) || ifa.busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_res1: bcd=%h busy=%b want %h 0",
                     ifa.bcd, ifa.busy, eb);
        end
        ifa.val   = v2[16:0];
        ifa.start = 1'b1;
        n = 0;
        for (int c = 1; c <= 40 && n == 0; c++) begin
            @(negedge clk);
            ifa.start = 1'b0;
            if (ifa.done) n = c;
        end
        checks++;
        if (n !== 18) begin
            errors++;
            $display("FAIL b2b_second: done@%0d want 18", n);
        end
        @(negedge clk);
        model(0, v2, eb, eo, es);
        checks++;
        if (ifa.bcd !== 24'(eb) || ifa.seg7 !== es[41:0]) begin
            errors++;
            $display("FAIL b2b_res2: bcd=%h seg=%h want %h %h",
                     ifa.bcd, ifa.seg7, eb, es);
        end
    endtask

    task automatic test_reset_mid();
        longint eb;
        bit eo;
        logic [47:0] es;
        int nd;
        vin[0] = 123456;
        vin[1] = 64'hD6;
        vin[2] = 200;
        vin[3] = 64'h80;
        run_conv(1'b0);
        @(negedge clk);
        for (int k = 0; k < 4; k++) set_in(k, rnd(k), 1'b1);
        @(negedge clk);
        for (int k = 0; k < 4; k++) set_in(k, 0, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            model(k, 0, eb, eo, es);
            checks++;
            if (obusy[k] !== 1'b0 || odone[k] !== 1'b0 ||
                oovf[k] !== 1'b0 || obcd[k] !== 64'd0 ||
                oseg[k] !== es) begin
                errors++;
                $display("FAIL midrst dut%0d: busy=%b done=%b ovf=%b bcd=%h seg=%h want 0 0 0 0 %h",
                         k, obusy[k], odone[k], oovf[k],
                         obcd[k], oseg[k], es);
            end
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        nd = 0;
        repeat (30) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) if (odone[k]) nd++;
        end
        checks++;
        if (nd !== 0) begin
            errors++;
            $display("FAIL midrst_done: saw %0d done want 0", nd);
        end
        for (int k = 0; k < 4; k++) vin[k] = rnd(k);
        run_conv(1'b0);
        for (int k = 0; k < 4; k++) begin
            model(k, vin[k], eb, eo, es);
            checks++;
            if (obcd[k] !== 64'(eb) || oseg[k] !== es ||
                ndone[k] !== 1) begin
                errors++;
                $display("FAIL postrst dut%0d: bcd=%h seg=%h n=%0d want %h %h 1",
                         k, obcd[k], oseg[k], ndone[k], eb, es);
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) set_in(k, 0, 1'b0);
        test_reset();
        test_directed();
        test_random();
        test_start_spam();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
